// File: rtl/vblank_update_sched.sv
// -----------------------------------------------------------------------------
// vblank_update_sched
//
// Per-frame game-logic scheduler. Once every FRAME_DIV vertical-blank rising
// edges it walks the game-logic clients 0..N_CLIENTS-1 in order. Each client
// gets a one-cycle start pulse and is then waited on until it returns its done
// pulse or a timeout expires. All game-state updates therefore land inside the
// blanking interval, between active frames.
//
// Ports
//   clk          pixel clock, the only clock
//   rst          asynchronous reset, active low
//   vblnk        vertical blank from the video timing generator
//   game_active  1 = game running; 0 = scheduler forced idle
//   clr_err      one-cycle pulse, clears timeout_err and overrun
//   done         per-client completion pulse (only the active client's bit counts)
//   start        one-hot, one-cycle start pulse to the active client
//   busy         high while a sequence is in progress
//   frame_tick   one-cycle pulse when a full sequence completes
//   frame_cnt    completed-sequence counter, wraps 0xFFFF -> 0
//   timeout_err  sticky, bit i set when client i timed out
//   overrun      sticky, sequence still busy at end of vblank or at next trigger
// -----------------------------------------------------------------------------
module vblank_update_sched #(
    parameter int N_CLIENTS = 4,
    parameter int TIMEOUT   = 4095,
    parameter int FRAME_DIV = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 vblnk,
    input  logic                 game_active,
    input  logic                 clr_err,
    input  logic [N_CLIENTS-1:0] done,
    output logic [N_CLIENTS-1:0] start,
    output logic                 busy,
    output logic                 frame_tick,
    output logic [15:0]          frame_cnt,
    output logic [N_CLIENTS-1:0] timeout_err,
    output logic                 overrun
);

    localparam int IDX_W = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;
    localparam int TMR_W = $clog2(TIMEOUT);
    localparam int DIV_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_CLIENTS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FRAME_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [TMR_W-1:0]       timer_q, timer_d;
    logic [DIV_W-1:0]       div_cnt_q, div_cnt_d;
    logic                   vblnk_prev_q;
    logic                   busy_q, busy_d;
    logic [15:0]            frame_cnt_q, frame_cnt_d;
    logic [N_CLIENTS-1:0]   timeout_err_q, timeout_err_d;
    logic                   overrun_q, overrun_d;

    logic                   rise;
    logic                   fall;
    logic                   trig;
    logic [N_CLIENTS-1:0]   err_set;

    assign rise = vblnk & ~vblnk_prev_q;
    assign fall = ~vblnk & vblnk_prev_q;

    // Frame divider: counts vblank rises while the game runs; a held-off game
    // restarts the count so the first sequence after resume is FRAME_DIV rises away.
    always_comb begin
        div_cnt_d = div_cnt_q;
        trig      = 1'b0;
        if (!game_active) begin
            div_cnt_d = '0;
        end else if (rise) begin
            if (div_cnt_q == DIV_LAST) begin
                trig      = 1'b1;
                div_cnt_d = '0;
            end else begin
                div_cnt_d = div_cnt_q + DIV_ONE;
            end
        end
    end

    // Sequencer next-state logic.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        timer_d     = timer_q;
        frame_cnt_d = frame_cnt_q;
        err_set     = '0;

        if (!game_active) begin
            // Abort: drop the sequence silently, no tick, no error.
            state_d = ST_IDLE;
            idx_d   = '0;
            timer_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (trig) begin
                        state_d = ST_START;
                        idx_d   = '0;
                    end
                end
                ST_START: begin
                    timer_d = '0;
                    state_d = ST_WAIT;
                end
                ST_WAIT: begin
                    timer_d = timer_q + TMR_ONE;
                    // done takes priority over a simultaneous timeout.
                    if (done[idx_q] || (timer_q == TMR_LAST)) begin
                        if (!done[idx_q]) begin
                            err_set[idx_q] = 1'b1;
                        end
                        timer_d = '0;
                        if (idx_q == IDX_LAST) begin
                            state_d = ST_DONE;
                        end else begin
                            idx_d   = idx_q + IDX_ONE;
                            state_d = ST_START;
                        end
                    end
                end
                ST_DONE: begin
                    frame_cnt_d = frame_cnt_q + 16'd1;
                    idx_d       = '0;
                    state_d     = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                end
            endcase
        end

        busy_d = (state_d != ST_IDLE);

        // Sticky flags: a set in the same cycle as clr_err survives.
        timeout_err_d = (timeout_err_q & ~{N_CLIENTS{clr_err}}) | err_set;
        overrun_d     = (overrun_q & ~clr_err) | ((fall | trig) & busy_q);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            idx_q         <= '0;
            timer_q       <= '0;
            div_cnt_q     <= '0;
            vblnk_prev_q  <= 1'b0;
            busy_q        <= 1'b0;
            frame_cnt_q   <= '0;
            timeout_err_q <= '0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            timer_q       <= timer_d;
            div_cnt_q     <= div_cnt_d;
            vblnk_prev_q  <= vblnk;
            busy_q        <= busy_d;
            frame_cnt_q   <= frame_cnt_d;
            timeout_err_q <= timeout_err_d;
            overrun_q     <= overrun_d;
        end
    end

    // Pulses are decoded from the registered state; gating with game_active
    // guarantees nothing is issued in the cycle the game is switched off.
    always_comb begin
        start = '0;
        if ((state_q == ST_START) && game_active) begin
            start[idx_q] = 1'b1;
        end
    end

    assign frame_tick  = (state_q == ST_DONE) && game_active;
    assign busy        = busy_q;
    assign frame_cnt   = frame_cnt_q;
    assign timeout_err = timeout_err_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_vblank_update_sched.sv
module tb_vblank_update_sched;

    logic        clk;
    logic        rst;
    logic        vblnk;
    logic        game_active;
    logic        clr_err;
    logic [3:0]  done;
    logic [3:0]  start;
    logic        busy;
    logic        frame_tick;
    logic [15:0] frame_cnt;
    logic [3:0]  timeout_err;
    logic        overrun;

    logic        vblnk3;
    logic        ga3;
    logic [3:0]  done3;
    logic [3:0]  start3;
    logic        busy3;
    logic        frame_tick3;
    logic [15:0] frame_cnt3;
    logic [3:0]  timeout_err3;
    logic        overrun3;

    int checks = 0;
    int passes = 0;

    vblank_update_sched #(.N_CLIENTS(4), .TIMEOUT(16), .FRAME_DIV(1)) dut (
        .clk(clk), .rst(rst), .vblnk(vblnk), .game_active(game_active),
        .clr_err(clr_err), .done(done), .start(start), .busy(busy),
        .frame_tick(frame_tick), .frame_cnt(frame_cnt),
        .timeout_err(timeout_err), .overrun(overrun)
    );

    vblank_update_sched #(.N_CLIENTS(4), .TIMEOUT(16), .FRAME_DIV(3)) dut3 (
        .clk(clk), .rst(rst), .vblnk(vblnk3), .game_active(ga3),
        .clr_err(clr_err), .done(done3), .start(start3), .busy(busy3),
        .frame_tick(frame_tick3), .frame_cnt(frame_cnt3),
        .timeout_err(timeout_err3), .overrun(overrun3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    // Called at the negedge of client i's START cycle. Drives done[i] in WAIT
    // cycle number resp (0 = never) and junk on the other bits; returns the
    // number of cycles until the next start pulse or frame_tick.
    task automatic run_client(input int i, input int resp, input logic [3:0] junk,
                              output int gap);
        logic [3:0] one;
        bit fin;
        one = 4'b0001;
        gap = 0;
        fin = 0;
        for (int k = 0; k < 64 && !fin; k++) begin
            step();
            gap++;
            if (start !== 4'b0000 || frame_tick === 1'b1 || busy !== 1'b1) begin
                done = 4'b0000;
                fin  = 1;
            end else begin
                done = (gap == resp) ? (one << i) : junk;
            end
        end
        if (!fin) begin
            checks++;
            done = 4'b0000;
            $display("FAIL client%0d_bound: no progress after %0d cycles, required advance", i, gap);
        end
    endtask

    task automatic test_reset();
        step();
        step();
        checks++; if (start !== 4'b0000) $display("FAIL rst_start: got %b want 0000", start); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else passes++;
        checks++; if (frame_tick !== 1'b0) $display("FAIL rst_tick: got %b want 0", frame_tick); else passes++;
        checks++; if (frame_cnt !== 16'h0000) $display("FAIL rst_cnt: got %h want 0000", frame_cnt); else passes++;
        checks++; if (timeout_err !== 4'b0000) $display("FAIL rst_err: got %b want 0000", timeout_err); else passes++;
        checks++; if (overrun !== 1'b0) $display("FAIL rst_overrun: got %b want 0", overrun); else passes++;
        rst = 1'b1;
        step();
        step();
        checks++; if (busy !== 1'b0 || start !== 4'b0000) $display("FAIL rst_release_idle: got busy=%b start=%b want 0/0000", busy, start); else passes++;
    endtask

    task automatic test_sequence();
        int g;
        logic [3:0] one;
        one = 4'b0001;
        checks++; if (start !== 4'b0000) $display("FAIL seq_pre_start: got %b want 0000", start); else passes++;
        vblnk = 1'b1;
        step();
        checks++; if (start !== 4'b0001) $display("FAIL seq_start0: got %b want 0001", start); else passes++;
        checks++; if (busy !== 1'b1) $display("FAIL seq_busy: got %b want 1", busy); else passes++;
        for (int i = 0; i < 4; i++) begin
            run_client(i, 1, 4'b0000, g);
            checks++; if (g != 2) $display("FAIL seq_gap%0d: got %0d want 2", i, g); else passes++;
            if (i < 3) begin
                checks++; if (start !== (one << (i + 1))) $display("FAIL seq_start%0d: got %b want %b", i + 1, start, one << (i + 1)); else passes++;
            end else begin
                checks++; if (frame_tick !== 1'b1) $display("FAIL seq_tick: got %b want 1", frame_tick); else passes++;
                checks++; if (frame_cnt !== 16'd0) $display("FAIL seq_cnt_during_tick: got %h want 0000", frame_cnt); else passes++;
            end
        end
        step();
        checks++; if (frame_tick !== 1'b0) $display("FAIL seq_tick_width: got %b want 0", frame_tick); else passes++;
        checks++; if (frame_cnt !== 16'd1) $display("FAIL seq_cnt: got %h want 0001", frame_cnt); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL seq_idle: got %b want 0", busy); else passes++;
        checks++; if (overrun !== 1'b0) $display("FAIL seq_overrun: got %b want 0", overrun); else passes++;
        vblnk = 1'b0;
        step();
    endtask

    task automatic test_timeout();
        int g;
        vblnk = 1'b1;
        step();
        checks++; if (start !== 4'b0001) $display("FAIL to_start0: got %b want 0001", start); else passes++;
        run_client(0, 1, 4'b0000, g);
        checks++; if (start !== 4'b0010) $display("FAIL to_start1: got %b want 0010", start); else passes++;
        // done lands in the same cycle as the timeout: done wins
        run_client(1, 16, 4'b0000, g);
        checks++; if (g != 17) $display("FAIL to_collide_gap: got %0d want 17", g); else passes++;
        checks++; if (timeout_err !== 4'b0000) $display("FAIL to_collide_err: got %b want 0000", timeout_err); else passes++;
        checks++; if (start !== 4'b0100) $display("FAIL to_start2: got %b want 0100", start); else passes++;
        // client 2 silent, other done bits toggling must be ignored
        run_client(2, 0, 4'b1011, g);
        checks++; if (g != 17) $display("FAIL to_gap: got %0d want 17", g); else passes++;
        checks++; if (start !== 4'b1000) $display("FAIL to_start3: got %b want 1000", start); else passes++;
        checks++; if (timeout_err !== 4'b0100) $display("FAIL to_err: got %b want 0100", timeout_err); else passes++;
        run_client(3, 1, 4'b0000, g);
        checks++; if (frame_tick !== 1'b1) $display("FAIL to_tick: got %b want 1", frame_tick); else passes++;
        step();
        checks++; if (frame_cnt !== 16'd2) $display("FAIL to_cnt: got %h want 0002", frame_cnt); else passes++;
        vblnk = 1'b0;
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        checks++; if (timeout_err !== 4'b0000) $display("FAIL to_clr: got %b want 0000", timeout_err); else passes++;
        checks++; if (overrun !== 1'b0) $display("FAIL to_no_overrun: got %b want 0", overrun); else passes++;
    endtask

    task automatic test_overrun_abort();
        vblnk = 1'b1;
        step();
        checks++; if (start !== 4'b0001) $display("FAIL ov_start0: got %b want 0001", start); else passes++;
        step();
        vblnk = 1'b0;
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        checks++; if (overrun !== 1'b1) $display("FAIL ov_set_vs_clr: got %b want 1", overrun); else passes++;
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        checks++; if (overrun !== 1'b0) $display("FAIL ov_clr: got %b want 0", overrun); else passes++;
        vblnk = 1'b1;
        step();
        checks++; if (overrun !== 1'b1) $display("FAIL ov_trig_busy: got %b want 1", overrun); else passes++;
        checks++; if (start !== 4'b0000 || busy !== 1'b1) $display("FAIL ov_drop: got start=%b busy=%b want 0000/1", start, busy); else passes++;
        done = 4'b0001;
        step();
        done = 4'b0000;
        checks++; if (start !== 4'b0010) $display("FAIL ov_continue: got %b want 0010", start); else passes++;
        step();
        game_active = 1'b0;
        step();
        checks++; if (busy !== 1'b0) $display("FAIL ab_busy: got %b want 0", busy); else passes++;
        checks++; if (start !== 4'b0000 || frame_tick !== 1'b0) $display("FAIL ab_quiet: got start=%b tick=%b want 0000/0", start, frame_tick); else passes++;
        vblnk = 1'b0;
        step();
        vblnk = 1'b1;
        step();
        checks++; if (start !== 4'b0000 || busy !== 1'b0) $display("FAIL ab_no_start_inactive: got start=%b busy=%b want 0000/0", start, busy); else passes++;
        step();
        checks++; if (frame_cnt !== 16'd2) $display("FAIL ab_cnt: got %h want 0002", frame_cnt); else passes++;
        checks++; if (timeout_err !== 4'b0000) $display("FAIL ab_err: got %b want 0000", timeout_err); else passes++;
        checks++; if (overrun !== 1'b1) $display("FAIL ov_sticky: got %b want 1", overrun); else passes++;
        vblnk = 1'b0;
        game_active = 1'b1;
        step();
    endtask

    task automatic test_reset_mid_wait();
        int g;
        vblnk = 1'b1;
        step();
        step();
        checks++; if (busy !== 1'b1) $display("FAIL rmw_busy_before: got %b want 1", busy); else passes++;
        rst = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || start !== 4'b0000) $display("FAIL rmw_busy_start: got busy=%b start=%b want 0/0000", busy, start); else passes++;
        checks++; if (frame_cnt !== 16'd0 || overrun !== 1'b0) $display("FAIL rmw_cnt_ov: got cnt=%h ov=%b want 0000/0", frame_cnt, overrun); else passes++;
        vblnk = 1'b0;
        step();
        step();
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            checks++; if (start !== 4'b0000 || busy !== 1'b0) $display("FAIL rmw_quiet%0d: got start=%b busy=%b want 0000/0", k, start, busy); else passes++;
        end
        vblnk = 1'b1;
        step();
        checks++; if (start !== 4'b0001) $display("FAIL rmw_restart: got %b want 0001", start); else passes++;
        for (int i = 0; i < 4; i++) run_client(i, 1, 4'b0000, g);
        step();
        checks++; if (frame_cnt !== 16'd1) $display("FAIL rmw_cnt: got %h want 0001", frame_cnt); else passes++;
        vblnk = 1'b0;
        step();
    endtask

    task automatic test_frame_div();
        logic [3:0] exp_tab [10];
        exp_tab = '{4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0001,
                    4'b0000, 4'b0000, 4'b0000, 4'b0001};
        for (int k = 0; k < 10; k++) begin
            if (k == 7) begin
                ga3 = 1'b0;
                step();
                ga3 = 1'b1;
                step();
            end
            vblnk3 = 1'b1;
            step();
            checks++; if (start3 !== exp_tab[k]) $display("FAIL div_rise%0d: got %b want %b", k + 1, start3, exp_tab[k]); else passes++;
            repeat (11) step();
            vblnk3 = 1'b0;
            step();
            step();
        end
        checks++; if (frame_cnt3 !== 16'd3) $display("FAIL div_cnt: got %h want 0003", frame_cnt3); else passes++;
    endtask

    task automatic test_wrap();
        int g;
        logic [15:0] exp_cnt [2];
        exp_cnt = '{16'hFFFF, 16'h0000};
        force dut.frame_cnt_q = 16'hFFFE;
        step();
        release dut.frame_cnt_q;
        step();
        checks++; if (frame_cnt !== 16'hFFFE) $display("FAIL wrap_preset: got %h want fffe", frame_cnt); else passes++;
        for (int f = 0; f < 2; f++) begin
            vblnk = 1'b1;
            step();
            for (int i = 0; i < 4; i++) run_client(i, 1, 4'b0000, g);
            checks++; if (frame_tick !== 1'b1) $display("FAIL wrap_tick%0d: got %b want 1", f, frame_tick); else passes++;
            step();
            vblnk = 1'b0;
            step();
            checks++; if (frame_cnt !== exp_cnt[f]) $display("FAIL wrap_cnt%0d: got %h want %h", f, frame_cnt, exp_cnt[f]); else passes++;
        end
    endtask

    initial begin
        rst = 1'b0;
        vblnk = 1'b0;
        game_active = 1'b1;
        clr_err = 1'b0;
        done = 4'b0000;
        vblnk3 = 1'b0;
        ga3 = 1'b1;
        done3 = 4'b1111;
        test_reset();
        test_sequence();
        test_timeout();
        test_overrun_abort();
        test_reset_mid_wait();
        test_frame_div();
        test_wrap();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
